// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: controller state encoding and the
// posted-write entry that travels through the write buffer.
package vram_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_RD_DRAIN,
    ST_RD_ISSUE,
    ST_RD_DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Video, CPU and RAM-side signals of the VRAM arbiter; slave is the arbiter,
// master is whoever drives the requests and models the RAM.
interface vram_arbiter_if #(
  parameter int LVL_W = 3
);
  import vram_pkg::*;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_dout;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic [LVL_W-1:0]  wbuf_level;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output vid_valid, vid_data, cpu_ack, cpu_dout, ram_addr, ram_we, ram_din,
           wbuf_level
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  vid_valid, vid_data, cpu_ack, cpu_dout, ram_addr, ram_we, ram_din,
           wbuf_level
  );

endinterface

// File: rtl/wbuf_fifo.sv
// Synchronous FIFO holding posted CPU writes; push and pop may coincide,
// including when full (the pop frees the slot the push takes).
module wbuf_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push,
  input  wbuf_entry_t            push_data,
  input  logic                   pop,
  output wbuf_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches, posted CPU writes and CPU reads
// share one registered RAM port with priority video > drain > read.
//
// state       | meaning
// ST_IDLE     | no CPU request pending; writes are posted from here
// ST_WR_WAIT  | write held because the buffer is full
// ST_RD_DRAIN | read pending, waiting for posted writes to drain
// ST_RD_ISSUE | read waiting to win the RAM port
// ST_RD_DONE  | read address on the RAM port, data returns next cycle
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int VID_LAT    = 2
) (
  input logic            clk_sys,
  input logic            reset,
  vram_arbiter_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic              cpu_new;
  logic              grant_vid;
  logic              grant_pop;
  logic              grant_rd;
  logic              push;
  logic              ack_set;
  logic              ack_rd;
  logic              cpu_ack_q;
  logic              rd_ack_q;
  logic [VID_LAT-1:0] vid_pipe;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              ram_we_q;
  wbuf_entry_t       push_data;
  wbuf_entry_t       head;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;

  wbuf_fifo #(.DEPTH(FIFO_DEPTH)) u_wbuf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (grant_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // the request is ignored during its own ack cycle so it is never taken twice
  assign cpu_new   = bus.cpu_req && !cpu_ack_q;
  assign grant_vid = bus.vid_req;
  assign grant_pop = !bus.vid_req && !empty;
  assign grant_rd  = !bus.vid_req && empty && (state == ST_RD_ISSUE);
  assign push_data = {bus.cpu_addr, bus.cpu_din};

  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cpu_new) begin
          if (bus.cpu_we) begin
            if (full && !grant_pop) state_nxt = ST_WR_WAIT;
          end else if (!empty) begin
            state_nxt = ST_RD_DRAIN;
          end else begin
            state_nxt = ST_RD_ISSUE;
          end
        end
      end
      ST_WR_WAIT:  if (grant_pop) state_nxt = ST_IDLE;
      ST_RD_DRAIN: if (empty)     state_nxt = ST_RD_ISSUE;
      ST_RD_ISSUE: if (grant_rd)  state_nxt = ST_RD_DONE;
      ST_RD_DONE:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    ack_set = 1'b0;
    ack_rd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_new && bus.cpu_we && (!full || grant_pop)) begin
          push    = 1'b1;
          ack_set = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (grant_pop) begin
          push    = 1'b1;
          ack_set = 1'b1;
        end
      end
      ST_RD_DONE: begin
        ack_set = 1'b1;
        ack_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_ack_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      vid_pipe  <= '0;
    end else begin
      cpu_ack_q <= ack_set;
      rd_ack_q  <= ack_rd;
      vid_pipe  <= {vid_pipe[VID_LAT-2:0], bus.vid_req};
    end
  end

  // address and write data hold their last value when the port is idle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (grant_vid) begin
        ram_addr_q <= bus.vid_addr;
      end else if (grant_pop) begin
        ram_addr_q <= head.addr;
        ram_din_q  <= head.data;
        ram_we_q   <= 1'b1;
      end else if (grant_rd) begin
        ram_addr_q <= bus.cpu_addr;
      end
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.vid_valid  = vid_pipe[VID_LAT-1];
  assign bus.vid_data   = vid_pipe[VID_LAT-1] ? bus.ram_dout : '0;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_dout   = rd_ack_q ? bus.ram_dout : '0;
  assign bus.wbuf_level = level;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the CPU write post buffer (power of two, 2..16).
REQ-002 SHALL have parameter VID_LAT, default 2, meaning the cycles from video request to vid_valid; only 2 is supported.
REQ-003 clk_sys  input  1  master clock; the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 vid_req  input  1  video fetch request, one-cycle pulse per slot.
REQ-006 vid_addr  input  15  video fetch address, valid with vid_req.
REQ-007 vid_valid  output  1  one-cycle pulse: vid_data holds the fetched byte.
REQ-008 vid_data  output  8  fetched video byte.
REQ-009 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-010 cpu_we  input  1  1 = write, 0 = read; valid with cpu_req.
REQ-011 cpu_addr  input  15  CPU address.
REQ-012 cpu_din  input  8  CPU write data.
REQ-013 cpu_ack  output  1  one-cycle pulse completing the CPU request.
REQ-014 cpu_dout  output  8  read data, valid with cpu_ack on a read.
REQ-015 ram_addr  output  15  single-port RAM address, registered.
REQ-016 ram_we  output  1  RAM write strobe, registered.
REQ-017 ram_din  output  8  RAM write data, registered.
REQ-018 ram_dout  input  8  RAM read data, valid one cycle after ram_addr.
REQ-019 wbuf_level  output  log2(FIFO_DEPTH)+1  current write-buffer occupancy.

Function
REQ-020 The RAM port SHALL carry at most one access per clk_sys cycle; each cycle's owner is chosen by fixed priority: video > write-buffer drain > CPU read.
REQ-021 A vid_req sampled in cycle N SHALL drive ram_addr=vid_addr, ram_we=0 in N+1, and vid_valid=1 with vid_data=ram_dout in N+2, unconditionally.
REQ-022 A CPU write SHALL be acked in the cycle after it is sampled if the buffer is not full; the {addr,data} pair is pushed in the same cycle.
REQ-023 When the buffer is full, the write SHALL wait; cpu_ack follows the first cycle in which a slot frees, and a pop and push in the same cycle are legal.
REQ-024 In any cycle without video, a non-empty buffer SHALL pop its oldest entry onto ram_addr/ram_din with ram_we=1. Drain order is FIFO.
REQ-025 A CPU read SHALL be issued only when the buffer is empty and no video access wins. Reads therefore never bypass posted writes.
REQ-026 A CPU read issued in cycle M SHALL give cpu_ack=1 with cpu_dout=ram_dout in M+1.
REQ-027 Controller FSM states: IDLE, WR_WAIT (buffer full), RD_DRAIN (read pending, buffer non-empty), RD_ISSUE, RD_DONE.
REQ-028 FSM transitions:
- IDLE->WR_WAIT on a write with the buffer full.
- IDLE->RD_DRAIN on a read with the buffer non-empty, else IDLE->RD_ISSUE.
- RD_DRAIN->RD_ISSUE when the buffer is empty.
- RD_ISSUE->RD_DONE when the read wins the port.
- RD_DONE->IDLE with cpu_ack.
- WR_WAIT->IDLE with cpu_ack.
REQ-029 A video request coinciding with RD_ISSUE SHALL delay the read by exactly one cycle per video slot.
REQ-030 Back-to-back vid_req on consecutive cycles SHALL be served every cycle; the CPU and the drain are starved for that interval.
REQ-031 cpu_ack SHALL never be asserted in two consecutive cycles for the same held request. After ack, the next cpu_req is sampled no earlier than the following cycle.
REQ-032 Outputs not carrying an access SHALL hold: ram_we=0, ram_addr and ram_din unchanged.

Reset
REQ-033 Reset SHALL set the following, with the FSM in IDLE and buffer pointers at zero:
- vid_valid=0, cpu_ack=0, ram_we=0, wbuf_level=0
- ram_addr=0, ram_din=0, vid_data=0, cpu_dout=0
REQ-034 Reset SHALL discard buffered writes without draining. An in-flight video or CPU access is abandoned with no vid_valid/cpu_ack.

Structure
REQ-035 The FSM state enum and the write-buffer entry type ({15-bit addr, 8-bit data}) SHALL live in shared package vram_pkg.
REQ-036 The write buffer SHALL be a sub-module, wbuf_fifo: synchronous FIFO with push, pop, full, empty and level.

Verification
REQ-037 vid_req at N with addr 0x1800, RAM holding 0x5A -> ram_addr=0x1800 at N+1; vid_valid=1 with vid_data=0x5A at N+2.
REQ-038 Four CPU writes to 0x4000..0x4003 while vid_req fires every cycle -> four acks, wbuf_level=4; a fifth write stalls until video stops; RAM is written in order 0x4000..0x4003.
REQ-039 Write 0x77 to 0x0100 immediately followed by a read of 0x0100 -> the read acks only after the drain, with cpu_dout=0x77.
REQ-040 Read request colliding with vid_req in the same cycle -> video served first; cpu_ack one cycle later than uncontended.
REQ-041 Reset asserted with wbuf_level=3 and a read in RD_DRAIN -> next cycle all outputs are zero and FSM is IDLE; no RAM writes occur.
REQ-042 Full buffer with simultaneous pop and push -> wbuf_level stays 4; the stalled write is acked in the pop cycle +1.
